// File: rtl/ctrl_ramdrv_pkg.sv
// Shared types and defaults for the RAM-driver read path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ctrl_ramdrv_pkg;

    localparam int DEF_DATA_OFFSET_WIDTH  = 10;
    localparam int DEF_VECTOR_INDEX_WIDTH = 4;

    // Reader sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } reader_state_t;

    // RAM read address at default widths: vector index in the upper bits
    typedef struct packed {
        logic [DEF_VECTOR_INDEX_WIDTH-1:0] index;
        logic [DEF_DATA_OFFSET_WIDTH-1:0]  offset;
    } ram_addr_t;

    // Head-offset store command encodings
    typedef enum logic [1:0] {
        HEAD_CMD_NOP = 2'd0,
        HEAD_CMD_RD  = 2'd1,
        HEAD_CMD_WR  = 2'd2,
        HEAD_CMD_CLR = 2'd3
    } head_cmd_t;

endpackage

// File: rtl/ctrl_ramdrv_ring_ptr.sv
// Ring pointer/counter: loads a head, steps backwards wrapping at len, flags the last step.
// Latency: pointer updates one cycle after load/advance; next/last outputs are combinational.
// Backpressure: advances only when i_adv is high; otherwise holds.
module ctrl_ramdrv_ring_ptr #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [DW-1:0] i_load_ptr,
    input  logic          i_adv,
    input  logic [DW-1:0] i_len,
    output logic [DW-1:0] o_next_ptr,
    output logic          o_last_next
);

    logic [DW-1:0] r_ptr;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] w_next_ptr;

    // Decrement with explicit wrap from 0 back to the ring's highest offset
    always_comb begin
        w_next_ptr = r_ptr - DW'(1);
        if (r_ptr == '0) begin
            w_next_ptr = i_len;
        end
    end

    // Pointer and emitted-count state: load restarts the walk, advance steps it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_ptr <= i_load_ptr;
            r_cnt <= '0;
        end else if (i_adv) begin
            r_ptr <= w_next_ptr;
            r_cnt <= r_cnt + DW'(1);
        end
    end

    assign o_next_ptr  = w_next_ptr;
    // The address produced by the next advance is the final one of the ring
    assign o_last_next = ((r_cnt + DW'(1)) == i_len);

endmodule

// File: rtl/ctrl_ramdrv_reader.sv
// Read sequencer: fetches a vector's head offset, then emits its ring addresses newest-first.
// Latency: start at N -> head_rd at N+1 -> first addr_valid at N+2, one address per handshake.
// Backpressure: valid/ready on addr; addr and addr_last hold while addr_ready is low.
// Optional CTRL_RAMDRV_READER_CHECK_EN adds a sticky err output for out-of-range or unknown heads.
module ctrl_ramdrv_reader
    import ctrl_ramdrv_pkg::*;
#(
    parameter int DATA_OFFSET_WIDTH  = DEF_DATA_OFFSET_WIDTH,
    parameter int VECTOR_INDEX_WIDTH = DEF_VECTOR_INDEX_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [VECTOR_INDEX_WIDTH-1:0]               index,
    input  logic [DATA_OFFSET_WIDTH-1:0]                length,
    output logic                                        head_rd,
    output logic [VECTOR_INDEX_WIDTH-1:0]               head_index,
    input  logic [DATA_OFFSET_WIDTH-1:0]                head_offset,
    output logic [VECTOR_INDEX_WIDTH+DATA_OFFSET_WIDTH-1:0] addr,
    output logic                                        addr_valid,
    input  logic                                        addr_ready,
    output logic                                        addr_last,
    output logic                                        busy,
    output logic                                        done
`ifdef CTRL_RAMDRV_READER_CHECK_EN
    ,
    output logic                                        err
`endif
);

    localparam int DW = DATA_OFFSET_WIDTH;
    localparam int IW = VECTOR_INDEX_WIDTH;

    reader_state_t       r_state;
    logic [IW-1:0]       r_idx;
    logic [DW-1:0]       r_len;
    logic [IW+DW-1:0]    r_addr;
    logic                r_addr_valid;
    logic                r_addr_last;
    logic                r_busy;
    logic                r_done;

    logic                w_hs;
    logic                w_adv;
    logic [DW-1:0]       w_load_ptr;
    logic [DW-1:0]       w_next_ptr;
    logic                w_last_next;

    assign w_hs  = r_addr_valid & addr_ready;
    assign w_adv = (r_state == STREAM) & w_hs & ~r_addr_last;

`ifdef CTRL_RAMDRV_READER_CHECK_EN
    logic w_head_oor;
    logic r_err;

    assign w_head_oor = (head_offset > r_len);
    // A head past the ring end is folded back once so the walk stays inside the ring
    assign w_load_ptr = w_head_oor ? (head_offset - (r_len + DW'(1))) : head_offset;

    // Sticky flag for a bad head seen during the fetch cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == FETCH) && (w_head_oor || $isunknown(head_offset))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_load_ptr = head_offset;
`endif

    ctrl_ramdrv_ring_ptr #(
        .DW (DW)
    ) u_ring_ptr (
        .clk         (clk),
        .rst         (rst),
        .i_load      (r_state == FETCH),
        .i_load_ptr  (w_load_ptr),
        .i_adv       (w_adv),
        .i_len       (r_len),
        .o_next_ptr  (w_next_ptr),
        .o_last_next (w_last_next)
    );

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_len        <= '0;
            r_addr       <= '0;
            r_addr_valid <= 1'b0;
            r_addr_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_idx   <= index;
                        r_len   <= length;
                        r_busy  <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_addr       <= {r_idx, w_load_ptr};
                    r_addr_valid <= 1'b1;
                    r_addr_last  <= (r_len == '0);
                    r_state      <= STREAM;
                end
                STREAM: begin
                    if (w_hs) begin
                        if (r_addr_last) begin
                            r_addr_valid <= 1'b0;
                            r_addr_last  <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= DONE;
                        end else begin
                            r_addr      <= {r_idx, w_next_ptr};
                            r_addr_last <= w_last_next;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign head_rd    = (r_state == FETCH);
    assign head_index = (r_state == FETCH) ? r_idx : '0;
    assign addr       = r_addr;
    assign addr_valid = r_addr_valid;
    assign addr_last  = r_addr_last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_ctrl_ramdrv_reader.sv
// Bench for ctrl_ramdrv_reader: scoreboard of expected addresses against the address stream.
// Latency/handshake timing checked around start, first valid and done.
// Ready patterns: always-on, 1-of-3, and random.
module tb_ctrl_ramdrv_reader;
    import ctrl_ramdrv_pkg::*;

    localparam int DW = 10;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [IW-1:0]     index;
    logic [DW-1:0]     length;
    logic              head_rd;
    logic [IW-1:0]     head_index;
    wire  [DW-1:0]     head_offset;
    logic [IW+DW-1:0]  addr;
    logic              addr_valid;
    logic              addr_ready;
    logic              addr_last;
    logic              busy;
    logic              done;
`ifdef CTRL_RAMDRV_READER_CHECK_EN
    logic              err;
`endif

    ctrl_ramdrv_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .index       (index),
        .length      (length),
        .head_rd     (head_rd),
        .head_index  (head_index),
        .head_offset (head_offset),
        .addr        (addr),
        .addr_valid  (addr_valid),
        .addr_ready  (addr_ready),
        .addr_last   (addr_last),
        .busy        (busy),
        .done        (done)
`ifdef CTRL_RAMDRV_READER_CHECK_EN
        ,
        .err         (err)
`endif
    );

    always #5 clk = ~clk;

    // Head store model: drives only during a read strobe
    logic [DW-1:0] head_mem [16];
    assign head_offset = head_rd ? head_mem[head_index] : 'z;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Scoreboard entries: {ram_addr_t, last}
    logic [IW+DW:0] sb_q[$];
    int             hs_cnt = 0;
    int             ready_mode = 0;
    int             rcyc = 0;

    // Ready driver, updated just after each rising edge
    initial begin
        addr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rcyc++;
            case (ready_mode)
                0:       addr_ready = 1'b1;
                1:       addr_ready = (rcyc % 3 == 0);
                default: addr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares each handshake against the scoreboard and checks hold-while-stalled
    logic             held_vld = 1'b0;
    logic [IW+DW-1:0] held_addr;
    logic             held_last;
    always @(negedge clk) begin
        logic [IW+DW:0] e;
        if (rst) begin
            held_vld = 1'b0;
        end else begin
            if (held_vld && addr_valid) begin
                check_eq("hold_addr", 32'(addr), 32'(held_addr));
                check_eq("hold_last", 32'(addr_last), 32'(held_last));
            end
            if (addr_valid && addr_ready) begin
                hs_cnt++;
                check_eq("sb_avail", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_eq("addr", 32'(addr), 32'(e[IW+DW:1]));
                    check_eq("addr_last", 32'(addr_last), 32'(e[0]));
                end
            end
            held_vld  = addr_valid && !addr_ready;
            held_addr = addr;
            held_last = addr_last;
        end
    end

    // Reference ring walk: head (folded if out of range) down to 0, then len down to head+1
    task automatic push_exp(input int idx, input int len, input int head);
        int p;
        ram_addr_t ea;
        p = (head > len) ? head - (len + 1) : head;
        for (int k = 0; k <= len; k++) begin
            ea.index  = IW'(idx);
            ea.offset = DW'(p);
            sb_q.push_back({ea, (k == len)});
            p = (p == 0) ? len : p - 1;
        end
    endtask

    task automatic issue_start(input int idx, input int len, input int head, input int mode);
        head_mem[idx] = DW'(head);
        hs_cnt        = 0;
        ready_mode    = mode;
        @(posedge clk); #1;
        start  = 1'b1;
        index  = IW'(idx);
        length = DW'(len);
        @(posedge clk); #1;
        start  = 1'b0;
        index  = '1;
        length = '0;
        @(negedge clk);
        check_eq("fetch_head_rd", 32'(head_rd), 32'd1);
        check_eq("fetch_head_index", 32'(head_index), 32'(idx));
        check_eq("fetch_busy", 32'(busy), 32'd1);
        check_eq("fetch_valid", 32'(addr_valid), 32'd0);
    endtask

    task automatic run_vec(input int idx, input int len, input int head, input int mode, input bit mid_start);
        int cyc;
        push_exp(idx, len, head);
        issue_start(idx, len, head, mode);
        cyc = 1;
        while (!done && cyc < 200) begin
            if (mid_start && cyc == 3) begin
                start  = 1'b1;
                index  = IW'(idx ^ 5);
                length = DW'(2);
            end else if (mid_start && cyc == 4) begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                check_eq("first_valid", 32'(addr_valid), 32'd1);
                check_eq("head_rd_off", 32'(head_rd), 32'd0);
`ifdef CTRL_RAMDRV_READER_CHECK_EN
                check_eq("err_after_fetch", 32'(err), 32'(head > len));
`endif
            end
            if (!done) check_eq("busy_stream", 32'(busy), 32'd1);
        end
        check_eq("done_seen", 32'(done), 32'd1);
        if (mode == 0) check_eq("done_latency", 32'(cyc), 32'(len + 3));
        check_eq("busy_at_done", 32'(busy), 32'd1);
        check_eq("hs_count", 32'(hs_cnt), 32'(len + 1));
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        check_eq("done_pulse_end", 32'(done), 32'd0);
        check_eq("busy_end", 32'(busy), 32'd0);
    endtask

    // Assert reset on the cycle of the third handshake and confirm the vector is abandoned
    task automatic run_abort(input int idx, input int len, input int head);
        push_exp(idx, len, head);
        issue_start(idx, len, head, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("abort_valid", 32'(addr_valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_addr", 32'(addr), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", 32'(done), 32'd0);
            check_eq("abort_idle_valid", 32'(addr_valid), 32'd0);
        end
        check_eq("abort_hs_count", 32'(hs_cnt), 32'd2);
        sb_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) head_mem[i] = '0;
        rst    = 1'b1;
        start  = 1'b0;
        index  = '0;
        length = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", 32'(addr_valid), 32'd0);
        check_eq("rst_last", 32'(addr_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_head_rd", 32'(head_rd), 32'd0);
        check_eq("rst_head_index", 32'(head_index), 32'd0);
        check_eq("rst_addr", 32'(addr), 32'd0);
`ifdef CTRL_RAMDRV_READER_CHECK_EN
        check_eq("rst_err", 32'(err), 32'd0);
`endif
        rst = 1'b0;

        run_vec(3, 4, 2, 0, 1'b0);   // wrap through 0 to len
        run_vec(6, 0, 0, 0, 1'b0);   // single-entry ring
        run_vec(1, 7, 7, 1, 1'b0);   // head at top, stalled ready
        run_vec(4, 6, 3, 0, 1'b1);   // start during stream must be ignored
        run_vec(9, 3, 0, 0, 1'b0);   // head=0 wraps immediately
        run_abort(7, 5, 2);
        run_vec(7, 5, 2, 0, 1'b0);   // normal after abort
        run_vec(5, 9, 4, 2, 1'b0);   // random ready

`ifdef CTRL_RAMDRV_READER_CHECK_EN
        run_vec(2, 3, 5, 0, 1'b0);   // out-of-range head, folded to 1
        repeat (3) @(negedge clk);
        check_eq("err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("err_cleared", 32'(err), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ctrl_ramdrv_reader.md
Name: ctrl_ramdrv_reader

Overview:
- Read-side address sequencer for the per-vector circular sample buffers, and the consumer of the head-offset store.
- On start, it fetches the current head offset of one vector from the header block.
- It then walks the ring backwards from the head, newest sample first, wrapping at the vector length, and emits one RAM read address per handshake to the MAC datapath.
- Sits between the controller FSM, the head-offset store and the data RAM read port.

Parameters:
- DATA_OFFSET_WIDTH, 10, width of the in-vector offset, head and length.
- VECTOR_INDEX_WIDTH, 4, width of the vector index; up to 2**VECTOR_INDEX_WIDTH vectors.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to stream one vector; ignored unless idle.
- index  in  VECTOR_INDEX_WIDTH  vector to stream, sampled with start.
- length  in  DATA_OFFSET_WIDTH  highest ring offset (ring holds length+1 entries), sampled with start.
- head_rd  out  1  read strobe to the head store; it drives head_offset only while this is high.
- head_index  out  VECTOR_INDEX_WIDTH  index presented to the head store.
- head_offset  in  DATA_OFFSET_WIDTH  head value; valid only during a head_rd cycle, may be Z otherwise.
- addr  out  VECTOR_INDEX_WIDTH+DATA_OFFSET_WIDTH  RAM read address {vector index, offset}.
- addr_valid  out  1  addr is valid.
- addr_ready  in  1  consumer accepts addr.
- addr_last  out  1  marks the final address of the vector; qualified by addr_valid.
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse after the last handshake.

Behaviour:
- FSM states: IDLE, FETCH, STREAM, DONE. All outputs are registered except head_rd and head_index, which decode from state.
- Reset values: state IDLE; addr, head_index, counters 0; head_rd, addr_valid, addr_last, busy, done all 0.
- IDLE: on start, latch index into idx_q and length into len_q, then go to FETCH. A start while not in IDLE is dropped with no effect.
- FETCH (exactly 1 cycle):
  - head_rd=1 and head_index=idx_q.
  - At the clock edge: ptr<=head_offset, cnt<=0, addr<={idx_q, head_offset}, addr_valid<=1, addr_last<=(len_q==0).
  - Go to STREAM.
- Latency: start accepted at cycle N, head_rd at N+1, first addr_valid at N+2.
- STREAM, handshake rule: a handshake is addr_valid & addr_ready. Without a handshake, addr and addr_last hold stable.
- STREAM, on a handshake that is not last:
  - next pointer is len_q if ptr==0, otherwise ptr-1;
  - cnt increments;
  - addr updates to {idx_q, next pointer};
  - addr_last<=(cnt+1==len_q).
  - Back-to-back handshakes give one address per cycle.
- STREAM, on the last handshake: addr_valid<=0, addr_last<=0, go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy drops together with done.
- Every vector emits exactly len_q+1 addresses. The order is head, head-1, ..., 0, len_q, ..., head+1.
- Arithmetic: unsigned modulo-(len_q+1) decrement by explicit compare. No overflow is possible because ptr<=len_q always holds when head_offset<=length.
- Boundary cases:
  - length=0: a single address equal to head, with addr_last set.
  - head=0: the next address wraps to len_q.
  - head=length: a plain descending walk to 0.
- An out-of-range head (head_offset>length) is undefined without the optional feature.
- Reset in any state: immediate return to reset values next cycle. An in-flight vector is abandoned and no done pulse is produced.

Optional Feature:
- Macro: CTRL_RAMDRV_READER_CHECK_EN.
- When defined, the block adds an output port err (1 bit, reset 0, sticky until rst).
  - err is set in FETCH if head_offset>len_q or head_offset contains X/Z.
  - The stream still proceeds, using head_offset modulo (len_q+1) = head_offset-(len_q+1) if greater.
- When undefined, the err port and all check logic are absent.

Decomposition:
- Shared package ctrl_ramdrv_pkg:
  - DATA_OFFSET_WIDTH and VECTOR_INDEX_WIDTH defaults;
  - typedef reader_state_t enum {IDLE, FETCH, STREAM, DONE};
  - typedef ram_addr_t as packed {index, offset}.
  - The head-store command encodings also move here.
- Sub-module ctrl_ramdrv_ring_ptr: pointer/counter pair with load, dec-wrap and last-flag logic. The FSM stays in the top.

Test Plan:
- index=3, length=4, head=2, addr_ready=1 -> addresses {3,2},{3,1},{3,0},{3,4},{3,3} on consecutive cycles from N+2; addr_last on the 5th; done at N+7.
- length=0, head=0 -> one address {idx,0} with addr_last=1; done the cycle after the handshake.
- length=7, head=7, addr_ready toggled 1,0,0,1,... -> addr held stable while ready=0; sequence 7..0 complete; exactly 8 handshakes.
- start pulsed again during STREAM with a different index -> ignored; the original sequence is unchanged, and a new start after done is accepted.
- rst asserted at the third handshake of a length=5 stream -> next cycle addr_valid=0, busy=0, no done pulse; a following start streams normally.
- With CTRL_RAMDRV_READER_CHECK_EN: length=3, head=5 -> err=1 from FETCH+1 and held; 4 addresses still emitted; err cleared only by rst.
